// File: rtl/mem_stage_ctrl_pkg.sv
// Shared MEM-stage types: sequencer state encoding and default widths.
package mem_stage_ctrl_pkg;
  localparam int DATA_W_DEF  = 64;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;
endpackage

// File: rtl/mem_stage_ctrl_timeout_cnt.sv
// ACCESS-cycle counter: clears outside ACCESS, flags the LIMIT-th enabled cycle.
// Purely registered count; o_expired is combinational on the current count.
module mem_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Count is 0 in the first ACCESS cycle, so LIMIT-1 marks the LIMIT-th one.
  assign o_expired = i_en && (r_cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory sequencer: IDLE -> ACCESS (req until ack) -> DONE; min 2 stall cycles.
// Combinational stall freezes upstream while busy; MEM_TIMEOUT_EN adds an ACCESS abort timer.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_MEM,
  input  logic              memWrite_E_MEM,
  input  logic [DATA_W-1:0] ALU_out_MEM,
  input  logic [DATA_W-1:0] mem_Din_MEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err
);
  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  logic              w_op;
  logic              w_access;
  logic              w_ack_fire;
  logic              w_timeout;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  assign w_op       = mem_read_MEM | memWrite_E_MEM;
  assign w_access   = (r_state == ACCESS);
  assign w_ack_fire = w_access & dmem_ack;

`ifdef MEM_TIMEOUT_EN
  logic w_expired;
  logic r_err;

  mem_timeout_cnt #(.LIMIT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (!w_access),
    .i_en      (w_access),
    .o_expired (w_expired)
  );

  // An ack landing on the last allowed cycle still counts as a good completion.
  assign w_timeout = w_expired & ~dmem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
    end
  end

  assign mem_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_op) w_state_nxt = ACCESS;
      ACCESS:  if (dmem_ack || w_timeout) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && w_op) begin
        r_we    <= memWrite_E_MEM;
        r_addr  <= ALU_out_MEM;
        r_wdata <= mem_Din_MEM;
      end
      // Stores and aborted accesses leave zero behind rather than stale load data.
      if (w_ack_fire) begin
        r_rdata <= r_we ? '0 : dmem_rdata;
      end else if (w_timeout) begin
        r_rdata <= '0;
      end
    end
  end

  assign dmem_req   = w_access;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign mem_valid  = (r_state == DONE);
  assign mem_rdata  = r_rdata;
  assign stall      = reset & (((r_state == IDLE) & w_op) | w_access);
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_stage_ctrl;
  localparam int DW = 64;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_read_MEM = 1'b0;
  logic          memWrite_E_MEM = 1'b0;
  logic [DW-1:0] ALU_out_MEM = '0;
  logic [DW-1:0] mem_Din_MEM = '0;
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack = 1'b0;
  logic [DW-1:0] dmem_rdata = '0;
  logic          stall;
  logic          mem_valid;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .mem_read_MEM   (mem_read_MEM),
    .memWrite_E_MEM (memWrite_E_MEM),
    .ALU_out_MEM    (ALU_out_MEM),
    .mem_Din_MEM    (mem_Din_MEM),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .stall          (stall),
    .mem_valid      (mem_valid),
    .mem_rdata      (mem_rdata),
    .mem_err        (mem_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction model: one outstanding op, its age in ACCESS cycles, a one-cycle completion slot.
  bit            m_busy, m_done, m_we, m_err;
  logic [DW-1:0] m_addr, m_wdata, m_rdata;
  int            m_age;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_done = 0; m_we = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_age = 0;
    end else if (m_busy) begin
      m_age++;
      if (dmem_ack) begin
        m_busy  = 0;
        m_done  = 1;
        m_rdata = m_we ? '0 : dmem_rdata;
      end
`ifdef MEM_TIMEOUT_EN
      else if (m_age == TO) begin
        m_busy = 0; m_done = 1; m_err = 1; m_rdata = '0;
      end
`endif
    end else if (m_done) begin
      m_done = 0;
      m_err  = 0;
    end else if (mem_read_MEM || memWrite_E_MEM) begin
      m_busy  = 1;
      m_we    = memWrite_E_MEM;
      m_addr  = ALU_out_MEM;
      m_wdata = mem_Din_MEM;
      m_age   = 0;
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = reset && (m_busy || (!m_done && (mem_read_MEM || memWrite_E_MEM)));
    chk("cmp_stall", stall, exp_stall);
    chk("cmp_req", dmem_req, m_busy);
    chk("cmp_we", dmem_we, m_we);
    chk("cmp_addr", dmem_addr, m_addr);
    chk("cmp_wdata", dmem_wdata, m_wdata);
    chk("cmp_valid", mem_valid, m_done);
    chk("cmp_rdata", mem_rdata, m_rdata);
    chk("cmp_err", mem_err, m_err);
  end

  // Memory responder: acks after a per-transaction delay; optional stray acks while idle.
  int            force_delay = -1;
  bit            force_rd_en = 0;
  logic [DW-1:0] force_rd = '0;
  bit            stray_en = 0;
  int            mem_delay = 0;
  int            mem_cnt = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_ack = 1'b0;
      mem_cnt  = 0;
    end else begin
      #1;
      if (dmem_req) begin
        dmem_ack   = (mem_cnt == ((force_delay >= 0) ? force_delay : mem_delay));
        dmem_rdata = force_rd_en ? force_rd : {$urandom, $urandom};
        mem_cnt++;
      end else begin
        mem_cnt = 0;
`ifdef MEM_TIMEOUT_EN
        mem_delay = ($urandom_range(0, 4) == 0) ? 40 : int'($urandom_range(0, 4));
`else
        mem_delay = int'($urandom_range(0, 4));
`endif
        dmem_ack   = stray_en && ($urandom_range(0, 5) == 0);
        dmem_rdata = {$urandom, $urandom};
      end
    end
  end

  task automatic set_in(input bit rd, input bit wr, input logic [DW-1:0] a, input logic [DW-1:0] d);
    mem_read_MEM   = rd;
    memWrite_E_MEM = wr;
    ALU_out_MEM    = a;
    mem_Din_MEM    = d;
  endtask

  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  // Drives one op and observes until completion; caller is in an IDLE cycle just after the edge.
  task automatic run_op(input bit rd, input bit wr, input logic [DW-1:0] a, input logic [DW-1:0] d,
                        output int stall_n, output int req_n, output int first_req,
                        output logic [DW-1:0] rdat, output bit err, output bit stable_ok,
                        output bit done_ok);
    set_in(rd, wr, a, d);
    stall_n = 0; req_n = 0; first_req = -1; rdat = '0; err = 0; stable_ok = 1; done_ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (dmem_req) begin
        if (first_req < 0) first_req = i;
        req_n++;
        if (dmem_we !== wr || dmem_addr !== a || dmem_wdata !== d) stable_ok = 0;
      end
      if (mem_valid) begin
        rdat = mem_rdata; err = mem_err; done_ok = 1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            sn, rn, fr;
    logic [DW-1:0] rd_v;
    bit            er, st, ok;

    #1 reset = 1'b0;
    set_in(1, 1, 64'h40, 64'h55);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_rdata", mem_rdata, 0);

    // Zero-wait load straight out of reset.
    next_slot();
    force_delay = 0; force_rd_en = 1; force_rd = 64'hDEADBEEF;
    reset = 1'b1;
    run_op(1, 0, 64'h40, 64'h0, sn, rn, fr, rd_v, er, st, ok);
    chk("load0_done", ok, 1);
    chk("load0_stall_cycles", sn, 2);
    chk("load0_req_cycles", rn, 1);
    chk("load0_rdata", rd_v, 64'hDEADBEEF);
    next_slot(); set_in(0, 0, 0, 0);

    // Store with three-cycle ack delay.
    next_slot();
    force_delay = 3;
    run_op(0, 1, 64'h80, 64'h1234, sn, rn, fr, rd_v, er, st, ok);
    chk("store3_done", ok, 1);
    chk("store3_stall_cycles", sn, 5);
    chk("store3_req_cycles", rn, 4);
    chk("store3_stable", st, 1);
    chk("store3_rdata", rd_v, 0);
    next_slot(); set_in(0, 0, 0, 0);

    // Back-to-back load then store: req low for DONE plus one IDLE.
    next_slot();
    force_delay = 1; force_rd = 64'hCAFE0001;
    run_op(1, 0, 64'h100, 64'h0, sn, rn, fr, rd_v, er, st, ok);
    chk("b2b_load_done", ok, 1);
    chk("b2b_load_rdata", rd_v, 64'hCAFE0001);
    next_slot();
    force_delay = 2;
    run_op(0, 1, 64'h108, 64'h77, sn, rn, fr, rd_v, er, st, ok);
    chk("b2b_store_done", ok, 1);
    chk("b2b_req_gap", 1 + fr, 2);
    chk("b2b_store_rdata", rd_v, 0);
    next_slot(); set_in(0, 0, 0, 0);

    // Reset during ACCESS with no ack coming.
    next_slot();
    force_delay = 1000;
    set_in(1, 0, 64'h200, 64'h0);
    repeat (3) @(negedge clk);
    chk("midrst_req_before", dmem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_req_drop", dmem_req, 0);
    chk("midrst_stall_drop", stall, 0);
    chk("midrst_addr_drop", dmem_addr, 0);
    next_slot();
    force_delay = 2; force_rd = 64'h0BAD_F00D;
    reset = 1'b1;
    run_op(1, 0, 64'h300, 64'h0, sn, rn, fr, rd_v, er, st, ok);
    chk("midrst_restart_done", ok, 1);
    chk("midrst_restart_stall", sn, 4);
    chk("midrst_restart_rdata", rd_v, 64'h0BAD_F00D);
    next_slot(); set_in(0, 0, 0, 0);

`ifdef MEM_TIMEOUT_EN
    next_slot();
    force_delay = 1000;
    run_op(1, 0, 64'h400, 64'h0, sn, rn, fr, rd_v, er, st, ok);
    chk("timeout_done", ok, 1);
    chk("timeout_req_cycles", rn, TO);
    chk("timeout_err", er, 1);
    chk("timeout_rdata", rd_v, 0);
    next_slot(); set_in(0, 0, 0, 0);
`endif

    // Randomized traffic, including overlapping read/write and stray idle acks.
    next_slot();
    force_delay = -1; force_rd_en = 0; stray_en = 1;
    for (int c = 0; c < 3000; c++) begin
      set_in($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             {$urandom, $urandom}, {$urandom, $urandom});
      next_slot();
    end
    stray_en = 0;
    set_in(0, 0, 0, 0);
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("drain_idle", stall | dmem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Multi-cycle data-memory sequencer for the MEM stage of the 5-stage pipelined CPU. It takes the memory-control and operand outputs of the EX/MEM pipeline register, runs a req/ack transaction against a variable-latency data memory, and asserts a global stall that freezes PC, IF/ID, ID/EX and EX/MEM until the access completes. Load data and a completion strobe are presented to the MEM/WB register in the release cycle.

## Interface
Parameters:
- DATA_W, 64, data/address width
- TIMEOUT, 16, max ACCESS cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- mem_read_MEM  in  1  load in MEM stage
- memWrite_E_MEM  in  1  store in MEM stage
- ALU_out_MEM  in  DATA_W  effective address
- mem_Din_MEM  in  DATA_W  store data
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  DATA_W  latched address
- dmem_wdata  out  DATA_W  latched store data
- dmem_ack  in  1  memory completion, one cycle
- dmem_rdata  in  DATA_W  read data, valid with dmem_ack
- stall  out  1  freeze upstream registers, bubble into MEM/WB
- mem_valid  out  1  memory op completes this cycle
- mem_rdata  out  DATA_W  captured load data
- mem_err  out  1  access aborted by timeout

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: op = mem_read_MEM | memWrite_E_MEM. If op: latch address, store data, and we = memWrite_E_MEM; go to ACCESS. Otherwise stay.
- ACCESS: dmem_req = 1, with addr/wdata/we stable. On dmem_ack = 1: if read, capture dmem_rdata into mem_rdata; go to DONE.
- DONE: mem_valid = 1, stall = 0; the pipeline advances at this edge. Always returns to IDLE. A new op first seen in IDLE starts a fresh transaction. DONE never re-issues the op still held in EX/MEM.
- stall = (IDLE & op) | ACCESS. Combinational, so EX/MEM holds the op in its first cycle. Forced 0 while reset is asserted.
- Both read and write asserted: the write wins; mem_rdata is written 0.
- A store clears mem_rdata to 0.
- dmem_ack in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE. dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_rdata, mem_valid and mem_err are all 0.
- Latency: op visible at cycle 0 (IDLE, stall=1). Cycle 1 is ACCESS with req=1. An ack in cycle 1 gives DONE in cycle 2. Minimum 2 stall cycles; total = 2 + ack wait cycles.
- dmem_req falls the cycle after ack is sampled. Memory must not ack without req.
- Back-to-back memory ops: DONE, then IDLE (stall), then ACCESS. One idle cycle between transactions.
- Reset asserted mid-ACCESS: all outputs drop immediately; the transaction is abandoned and the memory must tolerate the dropped req.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A cycle counter runs in ACCESS and clears on entry.
  - If TIMEOUT cycles elapse with no ack, req drops and the FSM goes to DONE with mem_err = 1 and mem_rdata = 0.
  - mem_err is high only in DONE.
- Undefined: ACCESS waits indefinitely, mem_err is tied 0, and no counter is built.

## Structure
- Shared pipeline package holds:
  - enum mem_state_t {IDLE, ACCESS, DONE}
  - DATA_W default constant
- Sub-module mem_timeout_cnt: a clear/enable counter with an expired flag. It is instantiated only under MEM_TIMEOUT_EN.
- Latches use the team register and D_FF primitives, converted to active-low async reset.

## Test plan
- Reset: hold reset=0 with load inputs asserted -> all outputs 0, stall=0. Release -> IDLE, stall=1 that cycle.
- Load with zero-wait ack: addr 0x40, ack in the first ACCESS cycle with rdata 0xDEADBEEF -> stall high 2 cycles; DONE has mem_valid=1, mem_rdata=0xDEADBEEF.
- Store with 3-cycle ack delay: addr 0x80, data 0x1234 -> req/we/addr/wdata stable 4 cycles; stall high 5 cycles; mem_rdata=0.
- Back-to-back load then store -> exactly one IDLE cycle between req pulses; the load data is not overwritten before DONE.
- Reset asserted during ACCESS, ack never sent -> req drops asynchronously; after release, new op restarts cleanly.
- MEM_TIMEOUT_EN with TIMEOUT=16, no ack -> req drops after 16 ACCESS cycles; DONE with mem_err=1, mem_valid=1, mem_rdata=0.
